// File: rtl/encode_pkg.sv
// Shared definitions for the encode scheduler: FSM encodings and engine defaults.
package encode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RSTE = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Byte-count width used by the LZS encode engine.
  localparam int LZF_WIDTH_DEF = 20;

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: first asserted request at or after ptr, cyclic.
// Purely combinational; the caller registers the grant.
module rr_arb #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  gnt,
  output logic           gnt_vld
);

  logic [CW-1:0] idx;

  // Scan from the far end back to ptr so the closest requester overwrites the rest.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = CW'((int'(ptr) + i) % NCH);
      if (req[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encode_sched.sv
// Time-shares one LZS encode engine across NCH source channels.
// Grant (round-robin) -> hold engine in reset -> run with the granted FIFO
// muxed in -> one-cycle completion pulse back to that channel.
module encode_sched
  import encode_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CW        = 2,
  parameter int LZF_WIDTH = LZF_WIDTH_DEF,
  parameter int RST_CYC   = 4,
  parameter int TMO_W     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NCH-1:0]           ch_req,
  input  logic [NCH-1:0]           ch_src_empty,
  input  logic [NCH-1:0]           ch_last,
  input  logic [NCH*64-1:0]        ch_fi,
  input  logic [NCH*LZF_WIDTH-1:0] ch_fi_cnt,
  output logic [NCH-1:0]           ch_getn,
  output logic [NCH-1:0]           ch_done,
  output logic [NCH-1:0]           ch_err,
  input  logic                     dst_full,
  output logic                     enc_rst,
  output logic                     enc_ce,
  output logic [63:0]              enc_fi,
  output logic [LZF_WIDTH-1:0]     enc_fi_cnt,
  output logic                     enc_src_empty,
  output logic                     enc_last,
  output logic                     enc_fo_full,
  input  logic                     enc_src_getn,
  input  logic                     enc_endn,
  output logic [CW-1:0]            cur_ch,
  output logic                     busy
);

  localparam int             RCW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RCNT_LAST = RCW'(RST_CYC - 1);

  logic [NCH-1:0][63:0]          fi_a;
  logic [NCH-1:0][LZF_WIDTH-1:0] cnt_a;

  state_t         state, state_nxt;
  logic [CW-1:0]  rr_ptr, gnt;
  logic           gnt_vld;
  logic [RCW-1:0] rcnt;
  logic [TMO_W-1:0] wcnt, wcnt_nxt;
  logic           timeout, err_q;

  assign fi_a  = ch_fi;
  assign cnt_a = ch_fi_cnt;

  // Data and count follow the granted slice at all times; only the
  // handshake-side signals are gated to RUN.
  assign enc_fi      = fi_a[cur_ch];
  assign enc_fi_cnt  = cnt_a[cur_ch];
  assign enc_fo_full = dst_full;

  rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
    .req     (ch_req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  // Watchdog next value: any pop clears it, otherwise count up and stick at all-ones.
  always_comb begin
    wcnt_nxt = '0;
    if (enc_src_getn) wcnt_nxt = (wcnt == '1) ? wcnt : wcnt + 1'b1;
  end

  // Abort when this idle cycle would bring the watchdog to all-ones.
  assign timeout = enc_src_getn && (wcnt_nxt == '1);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and all engine/channel-side outputs.
  always_comb begin
    state_nxt     = state;
    enc_rst       = 1'b1;
    enc_ce        = 1'b0;
    busy          = 1'b1;
    enc_src_empty = 1'b1;
    enc_last      = 1'b0;
    ch_getn       = '1;
    ch_done       = '0;
    ch_err        = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (gnt_vld) state_nxt = ST_RSTE;
      end
      ST_RSTE: begin
        if (rcnt == RCNT_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        enc_rst         = 1'b0;
        enc_ce          = 1'b1;
        enc_src_empty   = ch_src_empty[cur_ch];
        enc_last        = ch_last[cur_ch];
        ch_getn[cur_ch] = enc_src_getn;
        if (!enc_endn || timeout) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        ch_done[cur_ch] = 1'b1;
        ch_err[cur_ch]  = err_q;
        state_nxt       = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant capture, round-robin pointer, reset-hold and watchdog counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_ch <= '0;
      rr_ptr <= '0;
      rcnt   <= '0;
      wcnt   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && gnt_vld) cur_ch <= gnt;
      if (state == ST_DONE)
        rr_ptr <= (cur_ch == CW'(NCH - 1)) ? '0 : cur_ch + 1'b1;
      rcnt <= (state == ST_RSTE) ? rcnt + 1'b1 : '0;
      wcnt <= (state == ST_RUN) ? wcnt_nxt : '0;
      // An end-of-job in the timeout cycle wins, so the job closes clean.
      if (state == ST_RUN) err_q <= timeout && enc_endn;
    end
  end

endmodule

// File: tb/tb_encode_sched.sv
// Scoreboard bench for encode_sched: a small engine model drives pops/end,
// a negedge monitor counts reset-hold, run and pop cycles per job and
// checks each completion pulse against the queued expectation.
module tb_encode_sched;

  localparam int NCH     = 4;
  localparam int CW      = 2;
  localparam int LZW     = 20;
  localparam int RST_CYC = 4;
  localparam int TMO_W   = 4;
  localparam int TMO_LAT = (1 << TMO_W) - 1;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic [NCH-1:0]     ch_req = '0;
  logic [NCH-1:0]     ch_src_empty = '1;
  logic [NCH-1:0]     ch_last = '0;
  logic [NCH*64-1:0]  ch_fi = '0;
  logic [NCH*LZW-1:0] ch_fi_cnt = '0;
  logic [NCH-1:0]     ch_getn, ch_done, ch_err;
  logic               dst_full = 1'b0;
  logic               enc_rst, enc_ce, enc_src_empty, enc_last, enc_fo_full, busy;
  logic [63:0]        enc_fi;
  logic [LZW-1:0]     enc_fi_cnt;
  logic               enc_src_getn = 1'b1;
  logic               enc_endn = 1'b1;
  logic [CW-1:0]      cur_ch;

  always #5 clk = ~clk;

  encode_sched #(.NCH(NCH), .CW(CW), .LZF_WIDTH(LZW), .RST_CYC(RST_CYC), .TMO_W(TMO_W)) dut (
    .clk(clk), .rstn(rstn), .ch_req(ch_req), .ch_src_empty(ch_src_empty), .ch_last(ch_last),
    .ch_fi(ch_fi), .ch_fi_cnt(ch_fi_cnt), .ch_getn(ch_getn), .ch_done(ch_done), .ch_err(ch_err),
    .dst_full(dst_full), .enc_rst(enc_rst), .enc_ce(enc_ce), .enc_fi(enc_fi),
    .enc_fi_cnt(enc_fi_cnt), .enc_src_empty(enc_src_empty), .enc_last(enc_last),
    .enc_fo_full(enc_fo_full), .enc_src_getn(enc_src_getn), .enc_endn(enc_endn),
    .cur_ch(cur_ch), .busy(busy)
  );

  typedef struct {
    int ch;
    bit err;
    int lat;
    int pops;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  int          n_chk = 0, n_err = 0, n_done = 0;
  int          rst_cyc = 0, run_cyc = 0;
  int          pop_cnt [NCH];
  int          npop = 0, emode = 0, k = 0;
  bit          iso = 1'b0;
  logic [63:0] fi_tab  [NCH];
  logic [LZW-1:0] cnt_tab [NCH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine model: inside RUN, pop/end per mode; outside RUN, optionally toggle
  // the strobes to prove they are ignored.
  always @(posedge clk) begin
    #1;
    if (enc_ce) begin
      case (emode)
        0: begin
          enc_src_getn = (k < npop) ? 1'b0 : 1'b1;
          enc_endn     = (k == npop) ? 1'b0 : 1'b1;
        end
        1: begin
          enc_src_getn = 1'b1;
          enc_endn     = 1'b1;
        end
        default: begin
          enc_src_getn = 1'b1;
          enc_endn     = (k == TMO_LAT - 1) ? 1'b0 : 1'b1;
        end
      endcase
      k++;
    end else begin
      k = 0;
      if (iso) begin
        enc_src_getn = ~enc_src_getn;
        enc_endn     = ~enc_endn;
      end else begin
        enc_src_getn = 1'b1;
        enc_endn     = 1'b1;
      end
    end
  end

  // Monitor: per-job counters and scoreboard compare on each completion pulse.
  always @(negedge clk) begin
    if (!rstn) begin
      rst_cyc = 0;
      run_cyc = 0;
      for (int i = 0; i < NCH; i++) pop_cnt[i] = 0;
    end else if (|ch_done) begin
      n_done++;
      if (sb.size() == 0) chk("done_unexpected", 64'(ch_done), 64'(0));
      else begin
        logic [NCH-1:0] dv;
        int other;
        e_m   = sb.pop_front();
        dv    = 4'b0001 << e_m.ch;
        other = 0;
        for (int i = 0; i < NCH; i++) if (i != e_m.ch) other += pop_cnt[i];
        chk("done_vec", 64'(ch_done), 64'(dv));
        chk("err_vec", 64'(ch_err), e_m.err ? 64'(dv) : 64'(0));
        chk("done_ch", 64'(cur_ch), 64'(e_m.ch));
        chk("rst_cycles", 64'(rst_cyc), 64'(RST_CYC));
        chk("run_cycles", 64'(run_cyc), 64'(e_m.lat));
        chk("pops", 64'(pop_cnt[e_m.ch]), 64'(e_m.pops));
        chk("pops_other", 64'(other), 64'(0));
      end
      rst_cyc = 0;
      run_cyc = 0;
      for (int i = 0; i < NCH; i++) pop_cnt[i] = 0;
    end else begin
      if (|ch_err) chk("stray_err", 64'(ch_err), 64'(0));
      if (busy && enc_rst) rst_cyc++;
      if (enc_ce) run_cyc++;
      for (int i = 0; i < NCH; i++) if (!ch_getn[i]) pop_cnt[i]++;
    end
  end

  task automatic wait_busy(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #2;
      if (busy) return;
    end
    chk("busy_timeout", 64'(busy), 64'(1));
  endtask

  task automatic wait_ce(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #2;
      if (enc_ce) return;
    end
    chk("run_timeout", 64'(enc_ce), 64'(1));
  endtask

  task automatic wait_jobs(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !busy) return;
    end
    chk("jobs_timeout", 64'(sb.size()) + 64'(busy), 64'(0));
  endtask

  task automatic chk_rst();
    chk("rst_enc_rst", 64'(enc_rst), 64'(1));
    chk("rst_enc_ce", 64'(enc_ce), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_getn", 64'(ch_getn), 64'(4'hF));
    chk("rst_done", 64'(ch_done), 64'(0));
    chk("rst_err", 64'(ch_err), 64'(0));
    chk("rst_empty", 64'(enc_src_empty), 64'(1));
    chk("rst_last", 64'(enc_last), 64'(0));
    chk("rst_cur_ch", 64'(cur_ch), 64'(0));
    chk("rst_fi", enc_fi, fi_tab[0]);
    chk("rst_fi_cnt", 64'(enc_fi_cnt), 64'(cnt_tab[0]));
  endtask

  initial begin
    int d0;
    for (int i = 0; i < NCH; i++) begin
      fi_tab[i]  = {32'hC0DE0000 | 32'(i), 32'hF00D0000 | 32'(i * 3 + 1)};
      cnt_tab[i] = LZW'(100 * i + 7);
      ch_fi[64*i +: 64]      = fi_tab[i];
      ch_fi_cnt[LZW*i +: LZW] = cnt_tab[i];
    end
    ch_src_empty = 4'b1011;
    ch_last      = 4'b0100;

    // Reset values and full pass-through.
    #1 rstn = 1'b0;
    #10;
    chk_rst();
    chk("fo_full_lo", 64'(enc_fo_full), 64'(0));
    dst_full = 1'b1;
    #1 chk("fo_full_hi", 64'(enc_fo_full), 64'(1));
    dst_full = 1'b0;
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);
    #2 chk("idle_busy", 64'(busy), 64'(0));

    // Single job on channel 2, three pops then end.
    npop = 3; emode = 0;
    sb.push_back('{ch: 2, err: 1'b0, lat: 4, pops: 3});
    ch_req = 4'b0100;
    wait_busy(10);
    ch_req = '0;
    chk("grant_ch2", 64'(cur_ch), 64'(2));
    wait_ce(20);
    @(negedge clk);
    chk("mux_fi", enc_fi, fi_tab[2]);
    chk("mux_cnt", 64'(enc_fi_cnt), 64'(cnt_tab[2]));
    chk("mux_empty", 64'(enc_src_empty), 64'(0));
    chk("mux_last", 64'(enc_last), 64'(1));
    chk("mux_getn", 64'(ch_getn), 64'(4'b1011));
    wait_jobs(50);

    // Strobes toggling in IDLE and RSTE must not pop or end the job.
    iso = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    npop = 0;
    d0 = n_done;
    sb.push_back('{ch: 0, err: 1'b0, lat: 1, pops: 0});
    ch_req = 4'b0001;
    wait_busy(10);
    ch_req = '0;
    wait_jobs(50);
    iso = 1'b0;
    chk("iso_done_cnt", 64'(n_done - d0), 64'(1));

    // Reset during RUN after one pop: immediate reset values, no completion.
    npop = 5;
    d0 = n_done;
    ch_req = 4'b0010;
    wait_busy(10);
    wait_ce(20);
    @(negedge clk); #1;
    chk("mid_pop", 64'(pop_cnt[1]), 64'(1));
    rstn = 1'b0;
    #1 chk_rst();
    ch_req = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_no_done", 64'(n_done - d0), 64'(0));
    chk("mid_idle", 64'(busy), 64'(0));

    // Fairness from a reset pointer: all request, two pops per job.
    npop = 2;
    sb.push_back('{ch: 0, err: 1'b0, lat: 3, pops: 2});
    sb.push_back('{ch: 1, err: 1'b0, lat: 3, pops: 2});
    sb.push_back('{ch: 2, err: 1'b0, lat: 3, pops: 2});
    sb.push_back('{ch: 3, err: 1'b0, lat: 3, pops: 2});
    sb.push_back('{ch: 0, err: 1'b0, lat: 3, pops: 2});
    ch_req = 4'hF;
    wait_jobs(200);
    ch_req = '0;
    repeat (3) @(posedge clk);
    #2 chk("fair_stop", 64'(busy), 64'(0));

    // Watchdog abort: engine never pops nor ends.
    emode = 1;
    sb.push_back('{ch: 3, err: 1'b1, lat: TMO_LAT, pops: 0});
    ch_req = 4'b1000;
    wait_busy(10);
    ch_req = '0;
    wait_jobs(60);

    // End-of-job on the exact timeout cycle closes clean.
    emode = 2;
    sb.push_back('{ch: 0, err: 1'b0, lat: TMO_LAT, pops: 0});
    ch_req = 4'b0001;
    wait_busy(10);
    ch_req = '0;
    wait_jobs(60);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
